// File: rtl/uv_recon_decode.sv
// VP8 decoder chroma rebuild: predict, dequantize, 4x4 inverse DCT, add and clip for 4 U + 4 V blocks.
// Latency 26 cycles start->done (UV_NZ_SKIP_EN: 2 fewer per all-zero block); start is ignored while busy or done.
module uv_recon_decode #(
  parameter int BLOCK_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic [1:0]                   mode_uv,
  input  logic [16*16*BLOCK_SIZE-1:0]  levels,
  input  logic [31:0]                  nz,
  input  logic [15:0]                  dq_dc,
  input  logic [15:0]                  dq_ac,
  input  logic [7:0]                   top_left_u,
  input  logic [7:0]                   top_left_v,
  input  logic [63:0]                  top_u,
  input  logic [63:0]                  top_v,
  input  logic [63:0]                  left_u,
  input  logic [63:0]                  left_v,
  output logic [8*16*BLOCK_SIZE-1:0]   out,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {IDLE, PRED, DEQ, VERT, HORZ, DONE} state_t;

  localparam int KW = $clog2(BLOCK_SIZE);
  localparam logic [KW-1:0] LAST_K = KW'(BLOCK_SIZE - 1);
  localparam logic signed [31:0] C1 = 32'sd85627;
  localparam logic signed [31:0] C2 = 32'sd35468;

  state_t state, state_nxt;
  logic [KW-1:0] k;
  logic [7:0] pred [128];
  logic [7:0] pred_nxt [128];
  logic signed [31:0] coef [16];
  logic signed [31:0] tmp [16];
  logic signed [31:0] deq [16];
  logic [127:0] vr [4];
  logic [127:0] hr [4];
  logic [7:0] hpix [16];
  logic [7:0] top_b [2][8];
  logic [7:0] left_b [2][8];
  logic [7:0] tl_b [2];
  logic [10:0] sum_t [2];
  logic [10:0] sum_l [2];
  logic [7:0] dc_v [2];
  int blk_base;
  int lvl_base;
  logic dense_first, dense_next, blk_skip;

  function automatic logic signed [31:0] mul(input logic signed [31:0] a, input logic signed [31:0] c);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{c[31]}}, c});
    return p[47:16];
  endfunction

  // One 4-point inverse DCT; result element 0 sits in bits [31:0].
  function automatic logic [127:0] bfly(input logic signed [31:0] i0, input logic signed [31:0] i1,
                                        input logic signed [31:0] i2, input logic signed [31:0] i3);
    logic signed [31:0] a, b, c, d;
    a = i0 + i2;
    b = i0 - i2;
    c = mul(i1, C2) - mul(i3, C1);
    d = mul(i1, C1) + mul(i3, C2);
    return {a - d, b - c, b + c, a + d};
  endfunction

  function automatic int zz(input int n);
    case (n)
      0: return 0;   1: return 1;   2: return 4;   3: return 8;
      4: return 5;   5: return 2;   6: return 3;   7: return 6;
      8: return 9;   9: return 12;  10: return 13; 11: return 10;
      12: return 7;  13: return 11; 14: return 14; default: return 15;
    endcase
  endfunction

  function automatic logic [7:0] clip32(input logic signed [31:0] v);
    if (v < 0) return 8'd0;
    else if (v > 255) return 8'd255;
    else return v[7:0];
  endfunction

  function automatic logic [7:0] tm_pix(input logic [7:0] t, input logic [7:0] l, input logic [7:0] tl);
    logic signed [9:0] s;
    s = $signed({2'b00, t}) + $signed({2'b00, l}) - $signed({2'b00, tl});
    if (s < 0) return 8'd0;
    else if (s > 255) return 8'd255;
    else return s[7:0];
  endfunction

`ifdef UV_NZ_SKIP_EN
  logic [BLOCK_SIZE-1:0] nzb;
  logic unused_nz;
  assign nzb = nz[16 +: BLOCK_SIZE];
  assign dense_first = nzb[0];
  assign dense_next = nzb[k + KW'(1)];
  assign blk_skip = ~nzb[k];
  assign unused_nz = ^{nz[31:16+BLOCK_SIZE], nz[15:0]};
`else
  logic unused_nz;
  assign dense_first = 1'b1;
  assign dense_next = 1'b1;
  assign blk_skip = 1'b0;
  assign unused_nz = ^nz;
`endif

  assign busy = (state != IDLE);
  assign blk_base = (int'(k) / 4) * 64 + ((int'(k) / 2) % 2) * 32 + (int'(k) % 2) * 4;
  assign lvl_base = int'(k) * 256;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      top_b[0][i] = top_u[i*8 +: 8];
      top_b[1][i] = top_v[i*8 +: 8];
      left_b[0][i] = left_u[i*8 +: 8];
      left_b[1][i] = left_v[i*8 +: 8];
    end
    tl_b[0] = top_left_u;
    tl_b[1] = top_left_v;
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      sum_t[p] = 11'(top_b[p][0]) + 11'(top_b[p][1]) + 11'(top_b[p][2]) + 11'(top_b[p][3])
               + 11'(top_b[p][4]) + 11'(top_b[p][5]) + 11'(top_b[p][6]) + 11'(top_b[p][7]);
      sum_l[p] = 11'(left_b[p][0]) + 11'(left_b[p][1]) + 11'(left_b[p][2]) + 11'(left_b[p][3])
               + 11'(left_b[p][4]) + 11'(left_b[p][5]) + 11'(left_b[p][6]) + 11'(left_b[p][7]);
    end
  end

  // DC edge cases: missing neighbours fall back to the available edge or mid-grey.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      if (x == '0 && y == '0) dc_v[p] = 8'd128;
      else if (y == '0) dc_v[p] = 8'((sum_l[p] + 11'd4) >> 3);
      else if (x == '0) dc_v[p] = 8'((sum_t[p] + 11'd4) >> 3);
      else dc_v[p] = 8'(({1'b0, sum_t[p]} + {1'b0, sum_l[p]} + 12'd8) >> 4);
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          case (mode_uv)
            2'd0: pred_nxt[p*64 + r*8 + c] = dc_v[p];
            2'd1: pred_nxt[p*64 + r*8 + c] = tm_pix(top_b[p][c], left_b[p][r], tl_b[p]);
            2'd2: pred_nxt[p*64 + r*8 + c] = top_b[p][c];
            default: pred_nxt[p*64 + r*8 + c] = left_b[p][r];
          endcase
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) deq[i] = '0;
    for (int n = 0; n < 16; n++) begin
      deq[zz(n)] = $signed({{16{levels[lvl_base + n*16 + 15]}}, levels[lvl_base + n*16 +: 16]})
                 * $signed({16'd0, (n == 0) ? dq_dc : dq_ac});
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      vr[i] = bfly(coef[i], coef[4+i], coef[8+i], coef[12+i]);
    end
  end

  // Row pass; a skipped block contributes a zero residual so the predictor passes through.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (blk_skip) hr[i] = '0;
      else hr[i] = bfly(tmp[i] + 32'sd4, tmp[4+i], tmp[8+i], tmp[12+i]);
      for (int j = 0; j < 4; j++) begin
        hpix[i*4 + j] = clip32($signed({24'd0, pred[blk_base + i*8 + j]})
                               + ($signed(hr[i][j*32 +: 32]) >>> 3));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !done) state_nxt = PRED;
      PRED: state_nxt = dense_first ? DEQ : HORZ;
      DEQ:  state_nxt = VERT;
      VERT: state_nxt = HORZ;
      HORZ: begin
        if (k == LAST_K) state_nxt = DONE;
        else state_nxt = dense_next ? DEQ : HORZ;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      done <= 1'b0;
      out <= '0;
      for (int i = 0; i < 128; i++) pred[i] <= '0;
      for (int i = 0; i < 16; i++) begin
        coef[i] <= '0;
        tmp[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      done <= (state == DONE);
      case (state)
        PRED: begin
          k <= '0;
          for (int i = 0; i < 128; i++) pred[i] <= pred_nxt[i];
        end
        DEQ: begin
          for (int i = 0; i < 16; i++) coef[i] <= deq[i];
        end
        VERT: begin
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) tmp[4*i + j] <= $signed(vr[i][j*32 +: 32]);
        end
        HORZ: begin
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) out[(blk_base + i*8 + j)*8 +: 8] <= hpix[i*4 + j];
          k <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uv_recon_decode.sv
// Randomized scoreboard bench for uv_recon_decode against a plain-arithmetic VP8 chroma model.
module tb_uv_recon_decode;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [9:0] x, y;
  logic [1:0] mode_uv;
  logic [2047:0] levels;
  logic [31:0] nz;
  logic [15:0] dq_dc, dq_ac;
  logic [7:0] top_left_u, top_left_v;
  logic [63:0] top_u, top_v, left_u, left_v;
  logic [1023:0] out;
  logic busy, done;

  typedef struct { logic [1023:0] o; int lat; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int ZZ[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int st_cyc = 0;
  int busy_cnt = 0;

  uv_recon_decode dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .mode_uv(mode_uv),
    .levels(levels), .nz(nz), .dq_dc(dq_dc), .dq_ac(dq_ac),
    .top_left_u(top_left_u), .top_left_v(top_left_v),
    .top_u(top_u), .top_v(top_v), .left_u(left_u), .left_v(left_v),
    .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int clip(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  function automatic int mulc(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 16);
  endfunction

  function automatic int pred_px(input int p, input int r, input int c);
    logic [63:0] tv, lv;
    int tl, st, sl;
    tv = (p != 0) ? top_v : top_u;
    lv = (p != 0) ? left_v : left_u;
    tl = (p != 0) ? int'(top_left_v) : int'(top_left_u);
    st = 0; sl = 0;
    for (int i = 0; i < 8; i++) begin
      st += int'(tv[i*8 +: 8]);
      sl += int'(lv[i*8 +: 8]);
    end
    case (mode_uv)
      2'd0: begin
        if (x == 0 && y == 0) return 128;
        else if (y == 0) return (sl + 4) >> 3;
        else if (x == 0) return (st + 4) >> 3;
        else return (st + sl + 8) >> 4;
      end
      2'd1: return clip(int'(tv[c*8 +: 8]) + int'(lv[r*8 +: 8]) - tl);
      2'd2: return int'(tv[c*8 +: 8]);
      default: return int'(lv[r*8 +: 8]);
    endcase
  endfunction

  function automatic logic [1023:0] model_out();
    logic [1023:0] o;
    int cf[16], tm[16], res[4];
    int a, b, c, d, pl, br, bc, pix, idx;
    shortint lv;
    bit sk;
    for (int k = 0; k < 8; k++) begin
      sk = 1'b0;
`ifdef UV_NZ_SKIP_EN
      sk = !nz[16+k];
`endif
      for (int n = 0; n < 16; n++) begin
        lv = shortint'(levels[k*256 + n*16 +: 16]);
        cf[ZZ[n]] = sk ? 0 : int'(lv) * ((n == 0) ? int'(dq_dc) : int'(dq_ac));
      end
      for (int i = 0; i < 4; i++) begin
        a = cf[i] + cf[8+i]; b = cf[i] - cf[8+i];
        c = mulc(cf[4+i], 35468) - mulc(cf[12+i], 85627);
        d = mulc(cf[4+i], 85627) + mulc(cf[12+i], 35468);
        tm[4*i] = a + d; tm[4*i+1] = b + c; tm[4*i+2] = b - c; tm[4*i+3] = a - d;
      end
      pl = k / 4; br = (k / 2) % 2; bc = k % 2;
      for (int i = 0; i < 4; i++) begin
        a = tm[i] + 4 + tm[8+i]; b = tm[i] + 4 - tm[8+i];
        c = mulc(tm[4+i], 35468) - mulc(tm[12+i], 85627);
        d = mulc(tm[4+i], 85627) + mulc(tm[12+i], 35468);
        res[0] = a + d; res[1] = b + c; res[2] = b - c; res[3] = a - d;
        for (int j = 0; j < 4; j++) begin
          pix = clip(pred_px(pl, br*4 + i, bc*4 + j) + (res[j] >>> 3));
          idx = pl*64 + (br*4 + i)*8 + bc*4 + j;
          o[idx*8 +: 8] = 8'(pix);
        end
      end
    end
    return o;
  endfunction

  function automatic int model_lat();
    int l;
    l = 26;
`ifdef UV_NZ_SKIP_EN
    for (int k = 0; k < 8; k++) if (!nz[16+k]) l -= 2;
`endif
    return l;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic clear_inputs();
    x = '0; y = '0; mode_uv = '0; levels = '0; nz = '0; dq_dc = '0; dq_ac = '0;
    top_left_u = '0; top_left_v = '0; top_u = '0; top_v = '0; left_u = '0; left_v = '0;
  endtask

  task automatic issue();
    exp_t ex;
    ex.o = model_out();
    ex.lat = model_lat();
    exp_q.push_back(ex);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    st_cyc = cyc;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80 && !done; i++) @(negedge clk);
    chk("done_arrived", int'(done), 1);
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst_n) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          int bad, first;
          e = exp_q.pop_front();
          bad = 0; first = -1;
          for (int p = 0; p < 128; p++)
            if (out[p*8 +: 8] !== e.o[p*8 +: 8]) begin
              bad++;
              if (first < 0) first = p;
            end
          checks++;
          if (bad != 0) begin
            errors++;
            $display("FAIL out_bytes %0d wrong, byte %0d got %0d expected %0d",
                     bad, first, out[first*8 +: 8], e.o[first*8 +: 8]);
          end
          chk("latency", cyc - st_cyc, e.lat);
          chk("busy_cycles", busy_cnt, e.lat);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    int bad, v, pl, r, c;
    clear_inputs();
    #1;
    chk("rst_out_zero", int'(out == '0), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // DC with no neighbours: mid-grey everywhere.
    issue(); wait_done();
    bad = 0;
    for (int p = 0; p < 128; p++) if (out[p*8 +: 8] != 8'd128) bad++;
    chk("tp_dc128", bad, 0);
    // start while done is high must be ignored.
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_at_done_ignored", int'(busy), 0);

    // Vertical prediction.
    clear_inputs(); mode_uv = 2'd2;
    for (int i = 0; i < 8; i++) top_u[i*8 +: 8] = 8'(10*i);
    top_v = {8{8'd7}};
    issue(); wait_done();
    bad = 0;
    for (int p = 0; p < 128; p++) begin
      v = (p < 64) ? 10*(p % 8) : 7;
      if (out[p*8 +: 8] != 8'(v)) bad++;
    end
    chk("tp_vert", bad, 0);

    // DC interior with one DC coefficient in block 0.
    clear_inputs(); x = 10'd1; y = 10'd1;
    top_u = {8{8'd100}}; top_v = top_u; left_u = top_u; left_v = top_u;
    levels[15:0] = 16'd1; dq_dc = 16'd8; nz[16] = 1'b1;
    issue(); wait_done();
    bad = 0;
    for (int p = 0; p < 128; p++) begin
      pl = p / 64; r = (p % 64) / 8; c = p % 8;
      v = (pl == 0 && r < 4 && c < 4) ? 101 : 100;
      if (out[p*8 +: 8] != 8'(v)) bad++;
    end
    chk("tp_dc_resid", bad, 0);

    // TrueMotion clipping at both ends.
    clear_inputs(); mode_uv = 2'd1;
    top_u = {8{8'd250}}; top_v = top_u; left_u = top_u; left_v = top_u;
    levels[5*256 +: 16] = 16'hFF9C; dq_dc = 16'd100; nz[21] = 1'b1;
    issue(); wait_done();
    bad = 0;
    for (int p = 0; p < 128; p++) begin
      pl = p / 64; r = (p % 64) / 8; c = p % 8;
      v = (pl == 1 && r < 4 && c >= 4) ? 0 : 255;
      if (out[p*8 +: 8] != 8'(v)) bad++;
    end
    chk("tp_tm_clip", bad, 0);

    // Second start while busy is ignored; latency check in the monitor confirms.
    clear_inputs(); mode_uv = 2'd3; left_u = {$urandom, $urandom}; nz = 32'hFFFF_FFFF;
    issue();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();
    repeat (35) @(negedge clk);

    // Reset in mid-flight.
    clear_inputs(); mode_uv = 2'd2; top_u = {8{8'h55}}; top_v = {8{8'h33}};
    issue();
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_zero", int'(out == '0), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(); wait_done();

`ifdef UV_NZ_SKIP_EN
    clear_inputs(); mode_uv = 2'd3;
    for (int i = 0; i < 8; i++) left_u[i*8 +: 8] = 8'(i);
    issue(); wait_done();
    bad = 0;
    for (int p = 0; p < 64; p++) if (out[p*8 +: 8] != 8'(p / 8)) bad++;
    chk("tp_skip_h", bad, 0);
`endif

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      clear_inputs();
      mode_uv = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      y = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      top_u = {$urandom, $urandom}; top_v = {$urandom, $urandom};
      left_u = {$urandom, $urandom}; left_v = {$urandom, $urandom};
      top_left_u = 8'($urandom); top_left_v = 8'($urandom);
      dq_dc = 16'($urandom_range(1, 200)); dq_ac = 16'($urandom_range(1, 200));
      if (t % 8 == 7) begin
        dq_dc = 16'($urandom); dq_ac = 16'($urandom);
      end
      nz = $urandom;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 2) != 0) nz[16+k] = 1'b0;
        for (int n = 0; n < 16; n++) begin
          v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) - 256 : 0;
          if (t % 8 == 7) v = int'($urandom_range(0, 65535)) - 32768;
          levels[k*256 + n*16 +: 16] = 16'(v);
        end
      end
      issue(); wait_done();
      @(negedge clk);
    end

    repeat (40) @(negedge clk);
    chk("no_pending_expect", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uv_recon_decode.md
# uv_recon_decode

Decoder-side chroma reconstruction for the VP8 macroblock pipeline; the inverse of the encoder's UV mode-selection and quantization stage. It takes the chosen chroma mode, the eight quantized 4x4 coefficient blocks in zigzag order, and the dequantizer steps. It then rebuilds the 8x8 U and V pixel planes by prediction, dequantization, 4x4 inverse DCT, add and clip. Output pixel layout is the same as the encoder's UV source and reconstruction buses, so decoder output is bit-exact against encoder reconstruction.

## Interface
Parameters:
- BLOCK_SIZE, 8: number of 4x4 chroma blocks per macroblock (4 U then 4 V)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- x, y  in  10 each  macroblock column/row; selects the DC edge case
- mode_uv  in  2  0=DC, 1=TM, 2=V, 3=H
- levels  in  16*16*BLOCK_SIZE  block k at [k*256+:256]; zigzag coefficient n at [n*16+:16], signed
- nz  in  32  bit 16+k set means block k has non-zero levels
- dq_dc, dq_ac  in  16 each  unsigned dequant steps
- top_left_u, top_left_v  in  8 each  corner pixels
- top_u, top_v, left_u, left_v  in  64 each  byte i at [i*8+:8]
- out  out  8*16*BLOCK_SIZE  U raster bytes 0..63, then V bytes 64..127; byte p at [p*8+:8]
- busy  out  1  high from PRED through DONE
- done  out  1  one-cycle pulse; out is valid from this cycle until the next PRED

## Operation
- FSM states: IDLE -> PRED -> DEQ -> VERT -> HORZ -> (k<7 ? DEQ : DONE) -> IDLE.
- IDLE: waits for start; the inputs are held stable by the upstream block until done.
- PRED: registers the 128-byte predictor; clears block counter k to 0.
  - DC: x=0,y=0 gives 128. y=0 gives (sum left + 4)>>3. x=0 gives (sum top + 4)>>3. Otherwise (sum top + sum left + 8)>>4. Computed per plane.
  - TM: clip255(top[c] + left[r] - top_left).
  - V: top[c].
  - H: left[r].
- DEQ: coef[zz[n]] = levels_n * (n==0 ? dq_dc : dq_ac), 32-bit signed.
  - zz = {0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15}.
- VERT: column pass into tmp (32-bit signed).
  - MUL(a,b) = (a*b)>>>16; C1 = 85627; C2 = 35468.
  - a = c0+c8, b = c0-c8.
  - c = MUL(c4,C2) - MUL(c12,C1).
  - d = MUL(c4,C1) + MUL(c12,C2).
  - Outputs are a+d, b+c, b-c, a-d.
- HORZ: row pass with dc = t0+4, same butterfly. Each result is arithmetically shifted right by 3, added to the predictor pixel, clipped to 0..255, and written into the out byte for block k.
  - Block k: plane = k>>2; block row/col = (k>>1)&1, k&1.
  - Then k increments.
- DONE: done=1 for one cycle; returns to IDLE.
- start while busy is ignored.
- Reset at any time: state IDLE, out=0, done=0, busy=0, k=0.

## Timing
- Reset values: out=0, done=0, busy=0.
- start sampled high at edge T: PRED at T+1; block k occupies T+2+3k .. T+4+3k; DONE at T+26.
- done is high in the cycle after edge T+26, i.e. 26 cycles after start.
- out bytes of block k update at the HORZ edge; all bytes are final when done is high.
- start asserted in the same cycle as done is ignored; a new start is accepted one cycle later.

## Configuration
- UV_NZ_SKIP_EN defined: a block with nz[16+k]=0 skips DEQ/VERT. It spends one HORZ cycle writing the predictor unchanged. Latency = 26 - 2*(number of skipped blocks); minimum 10 cycles.
- UV_NZ_SKIP_EN undefined: nz is ignored; all blocks take 3 cycles; latency is a fixed 26.

## Test plan
- mode 0, x=0, y=0, all levels 0, skip disabled: all 128 out bytes = 128; done exactly 26 cycles after start; busy high for 26 cycles.
- mode 2, top_u byte i = 10*i, top_v = 7, levels 0: U column c = 10*c in every row; all V = 7.
- mode 0, x=1, y=1, top/left all 100; block 0 n=0 level 1, dq_dc=8, nz bit16=1: block 0 pixels = 101; all other pixels = 100.
- mode 1, top=250, left=250, top_left=0, block 5 n=0 level -100, dq_dc=100: block 5 pixels 0 (clipped low); all other pixels 255 (clipped high).
- second start during busy: ignored, single done; rst_n low at cycle 12: out=0 and IDLE immediately, then a fresh start completes normally.
- UV_NZ_SKIP_EN, nz=0, mode 3, left_u byte r = r: done after 10 cycles; U row r = r.
